// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the op and state encodings plus the default latencies.
package e_mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: the result is computed when the op is
// accepted, then HI/LO are written after a fixed busy period.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e  state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [63:0] result, result_next;
    logic        div_zero, div_zero_next;
    logic [31:0] hi_next, lo_next;

    mdu_op_e     op_e;
    logic        accept;
    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;

    // Operand arithmetic; divide-by-zero and the signed overflow case are
    // steered away from the operators so no X or undefined value appears.
    always_comb begin
        op_e   = mdu_op_e'(op);
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (B != 32'd0) begin
            quot_u = A / B;
            rem_u  = A % B;
            if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                quot_s = 32'h8000_0000;
                rem_s  = 32'd0;
            end else begin
                quot_s = $signed(A) / $signed(B);
                rem_s  = $signed(A) % $signed(B);
            end
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        result_next   = result;
        div_zero_next = div_zero;
        hi_next       = HI;
        lo_next       = LO;
        accept        = 1'b0;

        case (state)
            ST_IDLE: accept = start;
            ST_MUL, ST_DIV: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = ST_IDLE;
                    accept     = start;
                    if (!div_zero) begin
                        hi_next = result[63:32];
                        lo_next = result[31:0];
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A new op may also be taken on the final busy cycle, after the
        // previous result has been committed above.
        if (accept) begin
            case (op_e)
                MDU_MULT, MDU_MULTU: begin
                    result_next   = (op_e == MDU_MULT) ? prod_s : prod_u;
                    div_zero_next = 1'b0;
                    cnt_next      = 4'(MULT_CYCLES);
                    state_next    = ST_MUL;
                end
                MDU_DIV: begin
                    result_next   = {rem_s, quot_s};
                    div_zero_next = (B == 32'd0);
                    cnt_next      = 4'(DIV_CYCLES);
                    state_next    = ST_DIV;
                end
                MDU_DIVU: begin
                    result_next   = {rem_u, quot_u};
                    div_zero_next = (B == 32'd0);
                    cnt_next      = 4'(DIV_CYCLES);
                    state_next    = ST_DIV;
                end
                MDU_MTHI: hi_next = A;
                MDU_MTLO: lo_next = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            result   <= 64'd0;
            div_zero <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            result   <= result_next;
            div_zero <= div_zero_next;
            HI       <= hi_next;
            LO       <= lo_next;
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases followed by random
// operations compared against an arithmetic model of HI/LO and busy length.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    e_mdu dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected busy length and HI/LO effect, from plain arithmetic rules.
    function automatic int exp_cycles(input logic [2:0] o);
        case (o)
            3'd1, 3'd2: return 5;
            3'd3, 3'd4: return 10;
            default:    return 0;
        endcase
    endfunction

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        longint unsigned up;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin
                p = 64'(sa * sb);
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd2: begin
                up = longint'(a) * longint'(b);
                p = up;
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            3'd3: if (b != 0) begin
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = ma / mb;
                r = ma % mb;
                if ((sa < 0) != (sb < 0)) q = -q;
                if (sa < 0) r = -r;
                lo_m = 32'(q); hi_m = 32'(r);
            end
            3'd4: if (b != 0) begin
                lo_m = a / b; hi_m = a % b;
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        count_busy(cycles);
        model(o, a, b);
        check({tag, ".cycles"}, 32'(cycles), 32'(exp_cycles(o)));
        check({tag, ".HI"}, HI, hi_m);
        check({tag, ".LO"}, LO, lo_m);
    endtask

    initial begin
        int cycles;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0;
        #12;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.HI", HI, 32'd0);
        check("reset.LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult_neg", 3'd1, 32'd3, 32'hFFFF_FFFE);
        run_op("divu_7_2", 3'd4, 32'd7, 32'd2);
        run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mthi", 3'd5, 32'h11, 32'd0);
        run_op("mtlo", 3'd6, 32'h22, 32'd0);
        run_op("div_by0", 3'd3, 32'd1234, 32'd0);
        run_op("divu_by0", 3'd4, 32'hDEAD_BEEF, 32'd0);
        run_op("none", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // MTLO issued while a multiply is in flight must be dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        @(negedge clk);
        start = 1'b1; op = 3'd6; A = 32'h55;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        count_busy(cycles);
        model(3'd2, 32'd2, 32'd3);
        check("mtlo_busy.LO", LO, 32'd6);
        check("mtlo_busy.HI", HI, 32'd0);

        // Second multiply issued on the last busy cycle chains directly.
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (4) @(negedge clk);
        check("chain.busy_last", 32'(busy), 32'd1);
        start = 1'b1; op = 3'd2; A = 32'd4; B = 32'd5;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("chain.LO_first", LO, 32'd6);
        count_busy(cycles);
        model(3'd2, 32'd4, 32'd5);
        check("chain.cycles", 32'(cycles), 32'd5);
        check("chain.LO_second", LO, 32'd20);

        // Reset three cycles into a multiply aborts it.
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 32'd9; B = 32'd9;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.HI", HI, 32'd0);
        check("rst_mid.LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (8) @(negedge clk);
        check("rst_after.busy", 32'(busy), 32'd0);
        check("rst_after.HI", HI, 32'd0);
        check("rst_after.LO", LO, 32'd0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
